// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp
// Description : Responder end of an sram-like request/response port, backed
//               by an on-chip word-addressed memory. Requests are accepted
//               with addr_ok, queued in order, and answered with
//               data_ok/rdata no earlier than LAT cycles after acceptance.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   AW    - word-address width, memory holds 2^AW 32-bit words
//   DEPTH - max accepted-but-unanswered requests (power of two, >= 2)
//   LAT   - minimum cycles from acceptance to data_ok (>= 1)
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   req         in   request valid
//   wr          in   1 = write, 0 = read
//   size        in   access size (informational only)
//   wstrb[3:0]  in   write byte enables, used only when wr = 1
//   addr[31:0]  in   byte address, word index = addr[AW+1:2]
//   wdata[31:0] in   write data
//   addr_ok     out  request accepted when req & addr_ok at a rising edge
//   data_ok     out  one-cycle response strobe
//   rdata[31:0] out  read data, valid with data_ok (0 for write responses)
//   outstanding out  number of queued responses
// Optional feature macro:
//   SRAM_LIKE_RESP_RAND_STALL_EN - LFSR-driven random stalls on acceptance
//   and on response release, for initiator robustness testing.
// ============================================================================
module sram_like_resp #(
    parameter int AW    = 12,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       wr,
    input  logic [1:0]                 size,
    input  logic [3:0]                 wstrb,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic                       addr_ok,
    output logic                       data_ok,
    output logic [31:0]                rdata,
    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]   C_CNT_INIT = CW'(LAT - 1);
    localparam logic [CNTW-1:0] C_DEPTH    = CNTW'(DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]     r_mem    [2**AW];
    logic            r_q_wr   [DEPTH];
    logic [31:0]     r_q_data [DEPTH];
    logic [CW-1:0]   r_q_cnt  [DEPTH];

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_data_ok;
    logic [31:0]     r_rdata;

    logic [AW-1:0]   w_idx;
    logic [DEPTH-1:0] w_valid;
    logic            w_space;
    logic            w_push;
    logic            w_head_ready;
    logic            w_pop;
    logic            w_accept_stall;
    logic            w_pop_stall;

    // Size and the address bits outside the word index carry no meaning here.
    logic            w_unused_ok;
    assign w_unused_ok = ^{size, addr[31:AW+2], addr[1:0]};

    assign w_idx = addr[AW+1:2];

    // ------------------------------------------------------------------
    // Optional random stall source
    // ------------------------------------------------------------------
`ifdef SRAM_LIKE_RESP_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11 (bit numbering from 1).
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_accept_stall = r_lfsr[0];
    assign w_pop_stall    = r_lfsr[1];
`else
    assign w_accept_stall = 1'b0;
    assign w_pop_stall    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake / queue control
    // ------------------------------------------------------------------
    // Acceptance looks only at the occupancy before the edge; a pop in the
    // same cycle does not free a slot early.
    assign w_space = (r_count < C_DEPTH);
    assign addr_ok = ~reset & w_space & ~w_accept_stall;
    assign w_push  = req & addr_ok;

    assign w_head_ready = (r_count != '0) && (r_q_cnt[r_rd_ptr] == '0);
    assign w_pop        = w_head_ready & ~w_pop_stall;

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] w_off;
            assign w_off       = PW'(gi) - r_rd_ptr;
            assign w_valid[gi] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointers, occupancy and per-entry latency counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_cnt[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (PW'(i) == r_wr_ptr)) begin
                    r_q_cnt[i] <= C_CNT_INIT;
                end else if (w_valid[i] && (r_q_cnt[i] != '0)) begin
                    r_q_cnt[i] <= r_q_cnt[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory and queue payload (not reset: contents survive a reset)
    // ------------------------------------------------------------------
    // The read captures the array before this edge's update, which is
    // exactly the content left by all earlier accepted writes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wr[r_wr_ptr]   <= wr;
            r_q_data[r_wr_ptr] <= wr ? 32'h0 : r_mem[w_idx];
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
        end else if (w_pop) begin
            r_data_ok <= 1'b1;
            r_rdata   <= r_q_wr[r_rd_ptr] ? 32'h0 : r_q_data[r_rd_ptr];
        end else begin
            r_data_ok <= 1'b0;
        end
    end

    assign data_ok     = r_data_ok;
    assign rdata       = r_rdata;
    assign outstanding = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_resp
// Description : Directed self-checking bench for sram_like_resp. Two
//               instances share stimulus: u_dut (LAT=2) for latency, data
//               and ordering, u_dutf (LAT=6) so the queue can actually fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_resp;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        addr_ok,   addr_ok_f;
    logic        data_ok,   data_ok_f;
    logic [31:0] rdata,     rdata_f;
    logic [2:0]  outstanding, outstanding_f;

    int n_cmp = 0;
    int n_err = 0;

    sram_like_resp #(.AW(12), .DEPTH(4), .LAT(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok),
        .data_ok(data_ok), .rdata(rdata), .outstanding(outstanding)
    );

    sram_like_resp #(.AW(12), .DEPTH(4), .LAT(6)) u_dutf (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok_f),
        .data_ok(data_ok_f), .rdata(rdata_f), .outstanding(outstanding_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        wr  = 1'b0;
        repeat (n) tick();
    endtask

    // Single write accepted at the next edge, then let both queues drain.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; wr = 1'b1; addr = a; wdata = d; wstrb = s; size = 2'd2;
        tick();
        idle(8);
    endtask

    task automatic test_reset();
        req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_ok got=%0b exp=0", data_ok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok_in_reset got=%0b exp=0", addr_ok); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL rst_addr_ok_after got=%0b exp=1", addr_ok); end
        tick();
    endtask

    task automatic test_latency();
        do_write(32'h10, 32'h12345678, 4'hF);
        req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'h0;
        #1;
        n_cmp++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL lat_addr_ok got=%0b exp=1", addr_ok); end
        tick();                     // accept edge T
        req = 1'b0;
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL lat_T got=%0b exp=0", data_ok); end
        n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL lat_outst got=%0d exp=1", outstanding); end
        tick();                     // T+1
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL lat_T1 got=%0b exp=0", data_ok); end
        tick();                     // T+2
        n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL lat_T2 got=%0b exp=1", data_ok); end
        n_cmp++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL lat_rdata got=%h exp=12345678", rdata); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL lat_outst_end got=%0d exp=0", outstanding); end
        tick();
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL lat_T3 got=%0b exp=0", data_ok); end
        n_cmp++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL lat_hold got=%h exp=12345678", rdata); end
        idle(8);
    endtask

    task automatic test_write_merge();
        do_write(32'h20, 32'h11223344, 4'hF);
        req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
        tick();                     // write accepted at W
        wr = 1'b0; wstrb = 4'h0;
        tick();                     // read accepted at W+1
        req = 1'b0;
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL wm_early got=%0b exp=0", data_ok); end
        tick();
        n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL wm_wresp_ok got=%0b exp=1", data_ok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL wm_wresp_data got=%h exp=0", rdata); end
        tick();
        n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL wm_rresp_ok got=%0b exp=1", data_ok); end
        n_cmp++; if (rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL wm_merge got=%h exp=11bb33dd", rdata); end
        // wstrb=0 write changes nothing but still answers
        req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
        tick();
        wr = 1'b0;
        tick();
        req = 1'b0;
        tick();
        n_cmp++; if (data_ok !== 1'b1 || rdata !== 32'h0) begin n_err++; $display("FAIL wm_zero_strb_resp got=%0b/%h exp=1/0", data_ok, rdata); end
        tick();
        n_cmp++; if (rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL wm_zero_strb_data got=%h exp=11bb33dd", rdata); end
        idle(8);
    endtask

    task automatic preload();
        for (int k = 0; k < 6; k++) begin
            do_write(32'h100 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF);
        end
    endtask

    task automatic test_back_to_back();
        int exp_o [6] = '{1, 2, 2, 2, 1, 0};
        bit exp_d [6] = '{0, 0, 1, 1, 1, 1};
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(4 * c);
            end else begin
                req = 1'b0;
            end
            tick();
            n_cmp++; if (outstanding !== 3'(exp_o[c])) begin n_err++; $display("FAIL b2b_outst[%0d] got=%0d exp=%0d", c, outstanding, exp_o[c]); end
            n_cmp++; if (data_ok !== exp_d[c]) begin n_err++; $display("FAIL b2b_data_ok[%0d] got=%0b exp=%0b", c, data_ok, exp_d[c]); end
            if (exp_d[c]) begin
                n_cmp++; if (rdata !== 32'hA0000000 + 32'(c - 2)) begin n_err++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", c, rdata, 32'hA0000000 + 32'(c - 2)); end
            end
        end
        idle(8);
    endtask

    // LAT=6 instance: fill to DEPTH, observe addr_ok drop and recovery.
    task automatic test_fill();
        bit exp_aok [8]  = '{1, 1, 1, 1, 0, 0, 0, 1};
        int exp_o   [14] = '{1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 1, 1, 1, 0};
        bit exp_d   [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        int k = 0;
        int r = 0;
        bit acc;
        for (int c = 0; c < 14; c++) begin
            acc = 1'b0;
            if (c < 8) begin
                req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(4 * k);
                #1;
                n_cmp++; if (addr_ok_f !== exp_aok[c]) begin n_err++; $display("FAIL fill_addr_ok[%0d] got=%0b exp=%0b", c, addr_ok_f, exp_aok[c]); end
                acc = addr_ok_f;
            end else begin
                req = 1'b0;
            end
            tick();
            if (acc) k++;
            n_cmp++; if (outstanding_f !== 3'(exp_o[c])) begin n_err++; $display("FAIL fill_outst[%0d] got=%0d exp=%0d", c, outstanding_f, exp_o[c]); end
            n_cmp++; if (data_ok_f !== exp_d[c]) begin n_err++; $display("FAIL fill_data_ok[%0d] got=%0b exp=%0b", c, data_ok_f, exp_d[c]); end
            if (exp_d[c]) begin
                n_cmp++; if (rdata_f !== 32'hA0000000 + 32'(r)) begin n_err++; $display("FAIL fill_rdata[%0d] got=%h exp=%h", c, rdata_f, 32'hA0000000 + 32'(r)); end
                r++;
            end
        end
        idle(8);
    endtask

    task automatic test_reset_mid();
        do_write(32'h40, 32'hCAFEF00D, 4'hF);
        for (int c = 0; c < 3; c++) begin
            req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(4 * c);
            tick();
        end
        req = 1'b0;
        n_cmp++; if (outstanding_f !== 3'd3) begin n_err++; $display("FAIL rm_outst_before got=%0d exp=3", outstanding_f); end
        n_cmp++; if (data_ok !== 1'b1 || rdata !== 32'hA0000000) begin n_err++; $display("FAIL rm_resp_before got=%0b/%h exp=1/a0000000", data_ok, rdata); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL rm_async_data_ok got=%0b exp=0", data_ok); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rm_async_rdata got=%h exp=0", rdata); end
        n_cmp++; if (outstanding_f !== 3'd0) begin n_err++; $display("FAIL rm_async_outst got=%0d exp=0", outstanding_f); end
        n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL rm_addr_ok got=%0b exp=0", addr_ok); end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++; if (data_ok !== 1'b0 || data_ok_f !== 1'b0) begin n_err++; $display("FAIL rm_no_resp[%0d] got=%0b/%0b exp=0/0", c, data_ok, data_ok_f); end
        end
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        tick();
        req = 1'b0;
        tick();
        tick();
        n_cmp++; if (data_ok !== 1'b1 || rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL rm_mem_kept got=%0b/%h exp=1/cafef00d", data_ok, rdata); end
        idle(8);
    endtask

    // Random traffic on u_dut against a scoreboard; timing-independent, so
    // it also covers the random-stall build.
    task automatic test_random();
        localparam int TOTAL = 216;
        logic [31:0] model [16];
        logic [31:0] expq [$];
        logic [31:0] exp_v;
        int n = 0;
        int cyc = 0;
        int cur_j = 0;
        bit acc;
        req = 1'b0;
        while ((n < TOTAL || expq.size() != 0) && cyc < 5000) begin
            if (!req && n < TOTAL && $urandom_range(0, 3) != 0) begin
                cur_j = (n < 16) ? n : int'($urandom_range(0, 15));
                wr    = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
                addr  = ($urandom() & 32'hFFFF_C003) | (32'(12'h080 + cur_j) << 2);
                wdata = $urandom();
                wstrb = (n < 16) ? 4'hF : 4'($urandom_range(0, 15));
                size  = 2'($urandom_range(0, 2));
                req   = 1'b1;
            end
            #1;
            acc = req && addr_ok;
            if (acc) begin
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) model[cur_j][8*b +: 8] = wdata[8*b +: 8];
                    end
                    expq.push_back(32'h0);
                end else begin
                    expq.push_back(model[cur_j]);
                end
                n++;
            end
            tick();
            if (acc) req = 1'b0;
            if (data_ok) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++; $display("FAIL rand_extra_resp got=1 exp=0 cyc=%0d", cyc);
                end else begin
                    exp_v = expq.pop_front();
                    if (rdata !== exp_v) begin n_err++; $display("FAIL rand_rdata got=%h exp=%h cyc=%0d", rdata, exp_v, cyc); end
                end
            end
            cyc++;
        end
        n_cmp++;
        if (n != TOTAL || expq.size() != 0) begin
            n_err++; $display("FAIL rand_complete accepted=%0d exp=%0d pending=%0d exp=0", n, TOTAL, expq.size());
        end
        idle(4);
    endtask

    initial begin
        test_reset();
`ifndef SRAM_LIKE_RESP_RAND_STALL_EN
        test_latency();
        test_write_merge();
        preload();
        test_back_to_back();
        test_fill();
        test_reset_mid();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
